// File: rtl/conv_engine_mc.sv
// conv_engine_mc: KxK sliding-window convolution over a raster pixel stream,
// time-multiplexed over NUM_CH register-loaded kernels, one channel per cycle.
//
// state      | meaning
// ST_ACCEPT  | ready_out high, pixels shift into line buffer / window
// ST_COMPUTE | window frozen, channel ch_cnt sent into the MAC pipeline
module conv_engine_mc #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int K          = 5,
    parameter int NUM_CH     = 6,
    localparam int KK        = K * K,
    localparam int DEPTH     = NUM_CH * (KK + 1),
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    output logic                  ready_out,
    output logic [OUT_WIDTH-1:0]  result,
    output logic [CH_W-1:0]       result_ch,
    output logic                  result_valid,
    output logic                  frame_done
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_WIN  = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(K - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic {ST_ACCEPT, ST_COMPUTE} state_t;

    state_t                         state;
    logic [COL_W-1:0]               col;
    logic [ROW_W-1:0]               row;
    logic [CH_W-1:0]                ch_cnt;
    logic                           last_win;
    logic                           accept;
    logic                           win_ok;

    logic signed [DATA_WIDTH-1:0]   wgt  [NUM_CH][KK];
    logic signed [DATA_WIDTH-1:0]   bias [NUM_CH];

    logic [DATA_WIDTH-1:0]          lb      [K-1][IMG_WIDTH];
    logic [DATA_WIDTH-1:0]          col_vec [K];
    logic signed [DATA_WIDTH-1:0]   win     [K][K];

    logic signed [2*DATA_WIDTH-1:0] prod_q [KK];
    logic signed [DATA_WIDTH-1:0]   bias_q;
    logic                           s1_valid;
    logic                           s1_last;
    logic [CH_W-1:0]                s1_ch;
    logic signed [OUT_WIDTH-1:0]    sum_c;

    assign accept = valid_in && ready_out;
    assign win_ok = (row >= ROW_WIN) && (col >= COL_WIN);

    // Column entering the window: K-1 buffered rows above plus the new pixel.
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            col_vec[i] = lb[i][col];
        end
        col_vec[K-1] = pixel_in;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < K - 1; i++) begin
                lb[i][col] <= col_vec[i+1];
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][K-1] <= col_vec[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int i = 0; i < KK; i++) begin
                    wgt[ch][i] <= '0;
                end
                bias[ch] <= '0;
            end
        end else if (cfg_we) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int i = 0; i < KK; i++) begin
                    if (cfg_addr == ADDR_W'(ch * (KK + 1) + i)) wgt[ch][i] <= cfg_data;
                end
                if (cfg_addr == ADDR_W'(ch * (KK + 1) + KK)) bias[ch] <= cfg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_ACCEPT;
            ready_out <= 1'b0;
            ch_cnt    <= '0;
            col       <= '0;
            row       <= '0;
            last_win  <= 1'b0;
        end else begin
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            case (state)
                ST_ACCEPT: begin
                    if (accept && win_ok) begin
                        state     <= ST_COMPUTE;
                        ready_out <= 1'b0;
                        ch_cnt    <= '0;
                        last_win  <= (row == ROW_LAST) && (col == COL_LAST);
                    end else begin
                        ready_out <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    if (ch_cnt == CH_LAST) begin
                        state     <= ST_ACCEPT;
                        ready_out <= 1'b1;
                    end else begin
                        ch_cnt <= ch_cnt + CH_W'(1);
                    end
                end
                default: state <= ST_ACCEPT;
            endcase
        end
    end

    // Stage 1 latches products so the adder tree has a full cycle to itself.
    always_ff @(posedge clk) begin
        if (state == ST_COMPUTE) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    prod_q[r*K+c] <= win[r][c] * wgt[ch_cnt][r*K+c];
                end
            end
            bias_q <= bias[ch_cnt];
        end
    end

    always_comb begin
        sum_c = OUT_WIDTH'(bias_q);
        for (int i = 0; i < KK; i++) begin
            sum_c = sum_c + OUT_WIDTH'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_last      <= 1'b0;
            s1_ch        <= '0;
            result       <= '0;
            result_ch    <= '0;
            result_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            s1_valid     <= (state == ST_COMPUTE);
            s1_ch        <= ch_cnt;
            s1_last      <= (state == ST_COMPUTE) && last_win && (ch_cnt == CH_LAST);
            result_valid <= s1_valid;
            frame_done   <= s1_last;
            if (s1_valid) begin
                result    <= sum_c;
                result_ch <= s1_ch;
            end
        end
    end

endmodule

// File: tb/tb_conv_engine_mc.sv
// Bench for conv_engine_mc: random images and kernels compared against a direct
// nested-loop convolution of the whole frame.
`timescale 1ns/1ps
module tb_conv_engine_mc;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int DW = 8;
    localparam int OW = 32;
    localparam int K  = 5;
    localparam int NC = 6;
    localparam int KK = K * K;
    localparam int AW = 8;
    localparam int CW = 3;
    localparam int NWIN = (W - K + 1) * (H - K + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] pixel_in = '0;
    logic          ready_out;
    logic [OW-1:0] result;
    logic [CW-1:0] result_ch;
    logic          result_valid;
    logic          frame_done;

    int total = 0;
    int bad = 0;

    int img [H][W];
    int wm  [NC][KK];
    int bm  [NC];

    int exp_val[$];
    int exp_ch[$];
    int exp_fd[$];
    int obs_val[$];
    int obs_ch[$];
    int obs_fd[$];
    int rdy_low[$];
    int fd_cnt = 0;
    int cyc = 0;
    int acc44_cyc = -1;
    int first_res_cyc = -1;

    conv_engine_mc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .valid_in     (valid_in),
        .pixel_in     (pixel_in),
        .ready_out    (ready_out),
        .result       (result),
        .result_ch    (result_ch),
        .result_valid (result_valid),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            obs_val.push_back(int'($signed(result)));
            obs_ch.push_back(int'(result_ch));
            obs_fd.push_back(int'(frame_done));
            if (first_res_cyc < 0) first_res_cyc = cyc;
        end
        if (rst_n && frame_done) fd_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic int conv_ref(int ch, int i, int j);
        int s = bm[ch];
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                s += img[i+r][j+c] * wm[ch][r*K+c];
        return s;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic rand_img();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = rnd8();
    endtask

    task automatic rand_cfg();
        for (int ch = 0; ch < NC; ch++) begin
            for (int i = 0; i < KK; i++) wm[ch][i] = rnd8();
            bm[ch] = rnd8();
        end
    endtask

    task automatic fill_cfg(input int wv, input int bv);
        for (int ch = 0; ch < NC; ch++) begin
            for (int i = 0; i < KK; i++) wm[ch][i] = wv;
            bm[ch] = bv;
        end
    endtask

    task automatic clear_obs();
        obs_val.delete(); obs_ch.delete(); obs_fd.delete();
        exp_val.delete(); exp_ch.delete(); exp_fd.delete();
        rdy_low.delete();
        fd_cnt = 0; acc44_cyc = -1; first_res_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; valid_in = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = DW'(data);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_cfg();
        for (int ch = 0; ch < NC; ch++) begin
            for (int i = 0; i < KK; i++) cfg_write(ch * (KK + 1) + i, wm[ch][i]);
            cfg_write(ch * (KK + 1) + KK, bm[ch]);
        end
    endtask

    task automatic send_pixel(input int r, input int c, input int gap);
        bit done;
        done = 1'b0;
        if (gap > 0) begin
            valid_in = 1'b0;
            repeat (gap) @(negedge clk);
        end
        valid_in = 1'b1;
        pixel_in = DW'(img[r][c]);
        for (int t = 0; t < 64 && !done; t++) begin
            bit rdy;
            rdy = ready_out;
            @(posedge clk);
            done = rdy;
            @(negedge clk);
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL accept_timeout: pixel (%0d,%0d) not accepted, ready_out=%b want 1", r, c, ready_out);
        end
        if (r == K - 1 && c == K - 1) acc44_cyc = cyc;
        if (r >= K - 1 && c >= K - 1) begin
            int n = 0;
            while (!ready_out && n < 50) begin
                n++;
                @(negedge clk);
            end
            rdy_low.push_back(n);
        end
    endtask

    task automatic stream(input int n, input int max_gap);
        for (int k = 0; k < n; k++) begin
            int g = 0;
            if (max_gap > 0 && $urandom_range(0, 3) == 0) g = int'($urandom_range(1, max_gap));
            send_pixel((k / W) % H, k % W, g);
        end
        valid_in = 1'b0;
    endtask

    task automatic build_expected(input int n);
        for (int k = 0; k < n; k++) begin
            int r = (k / W) % H;
            int c = k % W;
            if (r >= K - 1 && c >= K - 1)
                for (int ch = 0; ch < NC; ch++) begin
                    exp_val.push_back(conv_ref(ch, r - K + 1, c - K + 1));
                    exp_ch.push_back(ch);
                    exp_fd.push_back((r == H - 1 && c == W - 1 && ch == NC - 1) ? 1 : 0);
                end
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 3000 && obs_val.size() < exp_val.size(); t++) @(negedge clk);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0; cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", ready_out); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result got %0d want 0", result); end
        total++; if (result_ch !== '0) begin bad++; $display("FAIL reset_ch got %0d want 0", result_ch); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", result_valid); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready_release got %b want 1", ready_out); end
        clear_obs();
    endtask

    task automatic test_bias_only();
        do_reset();
        rand_img();
        for (int ch = 0; ch < NC; ch++) begin
            for (int i = 0; i < KK; i++) wm[ch][i] = 0;
            bm[ch] = ch + 1;
        end
        load_cfg();
        stream(W * H, 0);
        build_expected(W * H);
        wait_drain();
        total++; if (obs_val.size() !== NWIN * NC) begin bad++; $display("FAIL bias_only_count got %0d want %0d", obs_val.size(), NWIN * NC); end
        for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
            total++;
            if (obs_val[i] !== exp_val[i] || obs_ch[i] !== exp_ch[i] || obs_fd[i] !== exp_fd[i]) begin
                bad++;
                $display("FAIL bias_only[%0d] got val=%0d ch=%0d fd=%0d want val=%0d ch=%0d fd=%0d",
                         i, obs_val[i], obs_ch[i], obs_fd[i], exp_val[i], exp_ch[i], exp_fd[i]);
            end
        end
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL bias_only_frame_done got %0d pulses want 1", fd_cnt); end
    endtask

    task automatic test_center_tap();
        do_reset();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (r * W + c) % 100;
        fill_cfg(0, 0);
        wm[0][(K / 2) * K + K / 2] = 1;
        load_cfg();
        stream(10 * W, 0);
        build_expected(10 * W);
        wait_drain();
        total++; if (obs_val.size() !== exp_val.size()) begin bad++; $display("FAIL center_count got %0d want %0d", obs_val.size(), exp_val.size()); end
        for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
            total++;
            if (obs_val[i] !== exp_val[i] || obs_ch[i] !== exp_ch[i]) begin
                bad++;
                $display("FAIL center[%0d] got val=%0d ch=%0d want val=%0d ch=%0d", i, obs_val[i], obs_ch[i], exp_val[i], exp_ch[i]);
            end
        end
    endtask

    task automatic test_extremes();
        int wv [3] = '{1, -128, -128};
        int pv [3] = '{127, -128, 127};
        int bv [3] = '{-128, 0, 0};
        int lit [3] = '{3047, 409600, -406400};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            fill_cfg(wv[k], bv[k]);
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    img[r][c] = pv[k];
            load_cfg();
            stream(K * W, 0);
            build_expected(K * W);
            wait_drain();
            total++;
            if (obs_val.size() == 0 || obs_val[0] !== lit[k]) begin
                bad++;
                $display("FAIL extreme%0d_first got %0d (n=%0d) want %0d", k, (obs_val.size() > 0) ? obs_val[0] : 0, obs_val.size(), lit[k]);
            end
            total++; if (obs_val.size() !== exp_val.size()) begin bad++; $display("FAIL extreme%0d_count got %0d want %0d", k, obs_val.size(), exp_val.size()); end
            for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
                total++;
                if (obs_val[i] !== exp_val[i] || obs_ch[i] !== exp_ch[i]) begin
                    bad++;
                    $display("FAIL extreme%0d[%0d] got val=%0d ch=%0d want val=%0d ch=%0d", k, i, obs_val[i], obs_ch[i], exp_val[i], exp_ch[i]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        rand_img();
        rand_cfg();
        load_cfg();
        stream(W * H, 3);
        build_expected(W * H);
        wait_drain();
        total++; if (obs_val.size() !== exp_val.size()) begin bad++; $display("FAIL gaps_count got %0d want %0d", obs_val.size(), exp_val.size()); end
        for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
            total++;
            if (obs_val[i] !== exp_val[i] || obs_ch[i] !== exp_ch[i] || obs_fd[i] !== exp_fd[i]) begin
                bad++;
                $display("FAIL gaps[%0d] got val=%0d ch=%0d fd=%0d want val=%0d ch=%0d fd=%0d",
                         i, obs_val[i], obs_ch[i], obs_fd[i], exp_val[i], exp_ch[i], exp_fd[i]);
            end
        end
        total++; if (rdy_low.size() !== NWIN) begin bad++; $display("FAIL gaps_ready_windows got %0d want %0d", rdy_low.size(), NWIN); end
        for (int i = 0; i < rdy_low.size(); i++) begin
            total++;
            if (rdy_low[i] !== NC) begin bad++; $display("FAIL gaps_ready_low[%0d] got %0d cycles want %0d", i, rdy_low[i], NC); end
        end
        total++;
        if (first_res_cyc - acc44_cyc !== 2) begin
            bad++;
            $display("FAIL gaps_latency got %0d cycles want 2", first_res_cyc - acc44_cyc);
        end
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL gaps_frame_done got %0d pulses want 1", fd_cnt); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        rand_img();
        rand_cfg();
        load_cfg();
        stream(300, 0);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got %b want 0", ready_out); end
        total++; if (result !== '0) begin bad++; $display("FAIL mid_reset_result got %0d want 0", result); end
        total++; if (result_ch !== '0) begin bad++; $display("FAIL mid_reset_ch got %0d want 0", result_ch); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got %b want 0", result_valid); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL mid_reset_frame_done got %b want 0", frame_done); end
        rst_n = 1'b1;
        clear_obs();
        fill_cfg(0, 0);
        stream(K * W, 0);
        build_expected(K * W);
        wait_drain();
        total++; if (obs_val.size() !== exp_val.size()) begin bad++; $display("FAIL cleared_count got %0d want %0d", obs_val.size(), exp_val.size()); end
        for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
            total++;
            if (obs_val[i] !== exp_val[i]) begin bad++; $display("FAIL cleared[%0d] got %0d want %0d", i, obs_val[i], exp_val[i]); end
        end
        do_reset();
        rand_cfg();
        load_cfg();
        stream(W * H, 0);
        build_expected(W * H);
        wait_drain();
        total++; if (obs_val.size() !== exp_val.size()) begin bad++; $display("FAIL reload_count got %0d want %0d", obs_val.size(), exp_val.size()); end
        for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
            total++;
            if (obs_val[i] !== exp_val[i] || obs_ch[i] !== exp_ch[i] || obs_fd[i] !== exp_fd[i]) begin
                bad++;
                $display("FAIL reload[%0d] got val=%0d ch=%0d fd=%0d want val=%0d ch=%0d fd=%0d",
                         i, obs_val[i], obs_ch[i], obs_fd[i], exp_val[i], exp_ch[i], exp_fd[i]);
            end
        end
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL reload_frame_done got %0d pulses want 1", fd_cnt); end
    endtask

    task automatic test_bias_update();
        int nres;
        int nbad_delta;
        do_reset();
        rand_img();
        rand_cfg();
        bm[2] = 5;
        load_cfg();
        stream(W * H, 0);
        build_expected(W * H);
        wait_drain();
        cfg_write(2 * (KK + 1) + KK, -7);
        cfg_write(NC * (KK + 1), 55);
        bm[2] = -7;
        stream(W * H, 0);
        build_expected(W * H);
        wait_drain();
        nres = NWIN * NC;
        total++; if (obs_val.size() !== 2 * nres) begin bad++; $display("FAIL update_count got %0d want %0d", obs_val.size(), 2 * nres); end
        for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
            total++;
            if (obs_val[i] !== exp_val[i] || obs_ch[i] !== exp_ch[i] || obs_fd[i] !== exp_fd[i]) begin
                bad++;
                $display("FAIL update[%0d] got val=%0d ch=%0d fd=%0d want val=%0d ch=%0d fd=%0d",
                         i, obs_val[i], obs_ch[i], obs_fd[i], exp_val[i], exp_ch[i], exp_fd[i]);
            end
        end
        nbad_delta = 0;
        for (int i = 0; i < nres && i + nres < obs_val.size(); i++)
            if (obs_val[i+nres] - obs_val[i] !== ((exp_ch[i] == 2) ? -12 : 0)) nbad_delta++;
        total++;
        if (nbad_delta !== 0) begin bad++; $display("FAIL update_delta got %0d wrong frame-to-frame deltas want 0", nbad_delta); end
        total++; if (fd_cnt !== 2) begin bad++; $display("FAIL update_frame_done got %0d pulses want 2", fd_cnt); end
    endtask

    initial begin
        test_reset();
        test_bias_only();
        test_center_tap();
        test_extremes();
        test_gaps();
        test_reset_midframe();
        test_bias_update();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
